// File: rtl/mem_line_bridge.sv
// mem_line_bridge: accepts one cache-line request at a time and moves it as
// NBEATS = LINE_BITS/BUS_BITS beats over a narrow beat bus. Reads gather
// returned beats into a line; writes stream the line out LSB beat first.
// The registered response is presented for exactly one cycle.
//
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to enable a watchdog that
// forces a response (partial line, err set) after TIMEOUT idle bus cycles.
//
// Handshake: a bus beat command transfers on a cycle where bus_cmd_valid
// and bus_cmd_ready are both high; bus_cmd_valid and all cmd fields hold
// steady until that cycle. bus_rdata_valid is a one-cycle, in-order beat
// return with no back-pressure. mem_req_valid is held by the requester until
// mem_rsp_valid; mem_req_ack pulses in the capture cycle.
module mem_line_bridge #(
    parameter int           LINE_BITS = 128,
    parameter int           BUS_BITS  = 32,
    parameter int           ADDR_BITS = 64,
    parameter int           TAG_BITS  = 2,
    parameter logic [4:0]   RD_OP     = 5'd4,
    parameter logic [4:0]   WR_OP     = 5'd7,
    parameter int           TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_req_valid,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [LINE_BITS-1:0] mem_req_store_data,
    input  logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic [4:0]           mem_req_opcode,
    input  logic                 mem_req_insn,
    output logic                 mem_req_ack,
    output logic                 mem_rsp_valid,
    output logic [LINE_BITS-1:0] mem_rsp_load_data,
    output logic [TAG_BITS-1:0]  mem_rsp_tag,
    output logic [4:0]           mem_rsp_opcode,
    output logic                 bus_cmd_valid,
    input  logic                 bus_cmd_ready,
    output logic [ADDR_BITS-1:0] bus_cmd_addr,
    output logic                 bus_cmd_write,
    output logic                 bus_cmd_insn,
    output logic [BUS_BITS-1:0]  bus_wdata,
    input  logic                 bus_rdata_valid,
    input  logic [BUS_BITS-1:0]  bus_rdata,
    output logic                 busy,
    output logic                 err
);

    localparam int NBEATS     = LINE_BITS / BUS_BITS;
    localparam int CW         = $clog2(NBEATS) + 1;
    localparam int OFF        = $clog2(LINE_BITS / 8);
    localparam int BEAT_BYTES = BUS_BITS / 8;

    // Parameter sanity: at least two beats, and a watchdog limit that leaves room to count.
    if (NBEATS < 2 || TIMEOUT < 2) begin : g_bad_cfg
        $error("mem_line_bridge: NBEATS and TIMEOUT must both be >= 2");
    end

    typedef enum logic [1:0] {IDLE, CMD, RDATA, RSP} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [LINE_BITS-1:0]   wline_q, wline_d;
    logic [LINE_BITS-1:0]   rline_q, rline_d;
    logic [TAG_BITS-1:0]    tag_q, tag_d;
    logic [4:0]             op_q, op_d;
    logic                   insn_q, insn_d;
    logic [CW-1:0]          cmd_cnt_q, cmd_cnt_d;
    logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
    logic                   err_q, err_d;
    logic                   cmd_hs;
    logic                   rd_take;
    logic                   is_write;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT);
    logic [WW-1:0]          wd_q, wd_d;
`endif

    assign is_write = (op_q == WR_OP);
    assign cmd_hs   = (state_q == CMD) && bus_cmd_ready;
    assign rd_take  = bus_rdata_valid && ((state_q == CMD) || (state_q == RDATA))
                      && (rd_cnt_q < CW'(NBEATS));

    // Output decode: every output is a gated view of registered state.
    always_comb begin
        bus_cmd_valid     = (state_q == CMD);
        bus_cmd_addr      = '0;
        bus_cmd_write     = 1'b0;
        bus_cmd_insn      = 1'b0;
        bus_wdata         = '0;
        mem_rsp_valid     = (state_q == RSP);
        mem_rsp_load_data = '0;
        mem_rsp_tag       = '0;
        mem_rsp_opcode    = '0;
        busy              = (state_q != IDLE);
        err               = err_q;
        if (state_q == CMD) begin
            bus_cmd_addr  = addr_q + (ADDR_BITS'(cmd_cnt_q) * ADDR_BITS'(BEAT_BYTES));
            bus_cmd_write = is_write;
            bus_cmd_insn  = insn_q;
            if (is_write) begin
                bus_wdata = wline_q[cmd_cnt_q[CW-2:0]*BUS_BITS +: BUS_BITS];
            end
        end
        if (state_q == RSP) begin
            mem_rsp_load_data = rline_q;
            mem_rsp_tag       = tag_q;
            mem_rsp_opcode    = op_q;
        end
    end

    // Next-state logic: capture, beat sequencing, read gathering and error tracking.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        rline_d     = rline_q;
        tag_d       = tag_q;
        op_d        = op_q;
        insn_d      = insn_q;
        cmd_cnt_d   = cmd_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_d       = err_q;
        mem_req_ack = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        wd_d        = wd_q;
`endif

        // Read beats may land during CMD (even alongside a cmd handshake) or RDATA.
        if (rd_take) begin
            rline_d[rd_cnt_q[CW-2:0]*BUS_BITS +: BUS_BITS] = bus_rdata;
            rd_cnt_d = rd_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus_rdata_valid) err_d = 1'b1;
                if (mem_req_valid) begin
                    mem_req_ack      = 1'b1;
                    addr_d           = mem_req_addr;
                    addr_d[OFF-1:0]  = '0;
                    wline_d          = mem_req_store_data;
                    rline_d          = '0;
                    tag_d            = mem_req_tag;
                    op_d             = mem_req_opcode;
                    insn_d           = mem_req_insn;
                    cmd_cnt_d        = '0;
                    rd_cnt_d         = '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    wd_d             = '0;
`endif
                    if (mem_req_opcode == RD_OP || mem_req_opcode == WR_OP) begin
                        state_d = CMD;
                    end else begin
                        state_d = RSP;
                        err_d   = 1'b1;
                    end
                end
            end
            CMD: begin
                if (cmd_hs) begin
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    if (cmd_cnt_q == CW'(NBEATS - 1)) begin
                        if (is_write || rd_cnt_d == CW'(NBEATS)) state_d = RSP;
                        else                                     state_d = RDATA;
                    end
                end
            end
            RDATA: begin
                if (rd_cnt_d == CW'(NBEATS)) state_d = RSP;
            end
            RSP: begin
                if (bus_rdata_valid) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // Watchdog: the response appears TIMEOUT cycles after the last bus event.
        if (state_q == CMD || state_q == RDATA) begin
            if (cmd_hs || rd_take) begin
                wd_d = '0;
            end else if (wd_q == WW'(TIMEOUT - 2)) begin
                state_d = RSP;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wline_q   <= '0;
            rline_q   <= '0;
            tag_q     <= '0;
            op_q      <= '0;
            insn_q    <= 1'b0;
            cmd_cnt_q <= '0;
            rd_cnt_q  <= '0;
            err_q     <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            rline_q   <= rline_d;
            tag_q     <= tag_d;
            op_q      <= op_d;
            insn_q    <= insn_d;
            cmd_cnt_q <= cmd_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_q     <= err_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_line_bridge.sv
// Testbench for mem_line_bridge: directed requests, a bus responder with
// programmable stall/return behaviour, and a scoreboard monitor that checks
// every bus beat command and every response against expected queues.
module tb_mem_line_bridge;

    localparam logic [4:0] RD = 5'd4;
    localparam logic [4:0] WR = 5'd7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         mem_req_valid = 1'b0;
    logic [63:0]  mem_req_addr = '0;
    logic [127:0] mem_req_store_data = '0;
    logic [1:0]   mem_req_tag = '0;
    logic [4:0]   mem_req_opcode = '0;
    logic         mem_req_insn = 1'b0;
    logic         mem_req_ack;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_load_data;
    logic [1:0]   mem_rsp_tag;
    logic [4:0]   mem_rsp_opcode;
    logic         bus_cmd_valid;
    logic         bus_cmd_ready = 1'b1;
    logic [63:0]  bus_cmd_addr;
    logic         bus_cmd_write;
    logic         bus_cmd_insn;
    logic [31:0]  bus_wdata;
    logic         bus_rdata_valid = 1'b0;
    logic [31:0]  bus_rdata = '0;
    logic         busy;
    logic         err;

    mem_line_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_store_data(mem_req_store_data), .mem_req_tag(mem_req_tag),
        .mem_req_opcode(mem_req_opcode), .mem_req_insn(mem_req_insn),
        .mem_req_ack(mem_req_ack), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_load_data(mem_rsp_load_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_opcode(mem_rsp_opcode), .bus_cmd_valid(bus_cmd_valid),
        .bus_cmd_ready(bus_cmd_ready), .bus_cmd_addr(bus_cmd_addr),
        .bus_cmd_write(bus_cmd_write), .bus_cmd_insn(bus_cmd_insn),
        .bus_wdata(bus_wdata), .bus_rdata_valid(bus_rdata_valid),
        .bus_rdata(bus_rdata), .busy(busy), .err(err)
    );

    // ---------------- scoreboard ----------------
    logic [134:0] exp_rsp_q[$];   // {tag, opcode, load_data}
    logic [97:0]  exp_cmd_q[$];   // {addr, write, insn, wdata}
    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: compares every presented response and every beat command.
    initial begin
        logic [134:0] e_rsp;
        logic [97:0]  cur;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mem_req_ack) begin
                    ack_cnt++;
                    check("ack_only_in_idle", busy, 0);
                end
                if (mem_rsp_valid) begin
                    if (exp_rsp_q.size() == 0) flag("rsp_unexpected");
                    else begin
                        e_rsp = exp_rsp_q.pop_front();
                        check("rsp_tag", mem_rsp_tag, e_rsp[134:133]);
                        check("rsp_opcode", mem_rsp_opcode, e_rsp[132:128]);
                        check("rsp_data", mem_rsp_load_data, e_rsp[127:0]);
                    end
                end
                if (bus_cmd_valid) begin
                    cur = {bus_cmd_addr, bus_cmd_write, bus_cmd_insn,
                           bus_cmd_write ? bus_wdata : 32'h0};
                    if (exp_cmd_q.size() == 0) flag("cmd_unexpected");
                    else begin
                        check("cmd_fields", cur, exp_cmd_q[0]);
                        if (bus_cmd_ready) void'(exp_cmd_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- bus responder ----------------
    int          hs_cnt = 0, rd_sent = 0, rd_limit = 4;
    int          stall_beat = -1, stall_left = 0;
    logic        stray_req = 1'b0;
    logic [31:0] rdata_vals[4];

    initial begin
        logic hs, hs_rd;
        forever begin
            @(negedge clk);
            hs    = reset_n && bus_cmd_valid && bus_cmd_ready;
            hs_rd = hs && !bus_cmd_write;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                bus_rdata_valid = 1'b0;
                hs_cnt  = 0;
                rd_sent = 0;
            end else begin
                if (hs) hs_cnt++;
                if (stray_req) begin
                    bus_rdata_valid = 1'b1;
                    bus_rdata       = 32'hDEAD_BEEF;
                    stray_req       = 1'b0;
                end else if (hs_rd && rd_sent < rd_limit) begin
                    bus_rdata_valid = 1'b1;
                    bus_rdata       = rdata_vals[rd_sent];
                    rd_sent++;
                end else begin
                    bus_rdata_valid = 1'b0;
                    bus_rdata       = '0;
                end
                if (hs_cnt == stall_beat && stall_left > 0) begin
                    bus_cmd_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus_cmd_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setup_bus(input int limit, input int sbeat, input int slen);
        hs_cnt = 0; rd_sent = 0; rd_limit = limit;
        stall_beat = sbeat; stall_left = slen;
    endtask

    task automatic push_cmds(input logic [63:0] base, input logic wr, input logic insn,
                             input logic [127:0] line);
        for (int i = 0; i < 4; i++)
            exp_cmd_q.push_back({base + 64'(4 * i), wr, insn, wr ? line[i*32 +: 32] : 32'h0});
    endtask

    task automatic issue_req(input logic [4:0] op, input logic [63:0] addr, input logic [127:0] data,
                             input logic [1:0] tag, input logic insn, output int acc);
        logic got = 1'b0;
        acc = 0;
        @(posedge clk);
        #1;
        ack_cnt            = 0;
        mem_req_valid      = 1'b1;
        mem_req_addr       = addr;
        mem_req_store_data = data;
        mem_req_tag        = tag;
        mem_req_opcode     = op;
        mem_req_insn       = insn;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (mem_req_ack) begin got = 1'b1; acc = cyc; end
        end
        if (!got) flag("ack_timeout");
    endtask

    task automatic wait_rsp(input int acc, input int exp_cycles);
        logic got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (mem_rsp_valid) begin
                got = 1'b1;
                check("latency", cyc - acc + 1, exp_cycles);
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_timeout: got no response expected one within 200 cycles");
        end
        check("ack_count", ack_cnt, 1);
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {mem_req_ack, mem_rsp_valid, bus_cmd_valid, bus_cmd_write,
                                bus_cmd_insn, busy, err}, 0);
        check({name, "_rsp"}, {mem_rsp_tag, mem_rsp_opcode, mem_rsp_load_data}, 0);
        check({name, "_bus"}, {bus_cmd_addr, bus_wdata}, 0);
    endtask

    // Hard stop so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Line read, zero-wait bus: addrs +0..+C off the aligned line, 7 cycles.
        setup_bus(4, -1, 0);
        rdata_vals = '{32'h1111_00A0, 32'h2222_00A1, 32'h3333_00A2, 32'h4444_00A3};
        push_cmds(64'h8000_0000_0000_1230, 1'b0, 1'b1, '0);
        exp_rsp_q.push_back({2'b10, RD, 128'h4444_00A3_3333_00A2_2222_00A1_1111_00A0});
        issue_req(RD, 64'h8000_0000_0000_123C, '1, 2'b10, 1'b1, acc);
        wait_rsp(acc, 7);
        check("err_after_read", err, 0);

        // Line write at 0x1008: beats from 0x1000, LSB beat first, 6 cycles.
        setup_bus(4, -1, 0);
        exp_cmd_q.push_back({64'h1000, 1'b1, 1'b0, 32'h0302_0100});
        exp_cmd_q.push_back({64'h1004, 1'b1, 1'b0, 32'h0706_0504});
        exp_cmd_q.push_back({64'h1008, 1'b1, 1'b0, 32'h0B0A_0908});
        exp_cmd_q.push_back({64'h100C, 1'b1, 1'b0, 32'h0F0E_0D0C});
        exp_rsp_q.push_back({2'b01, WR, 128'h0});
        issue_req(WR, 64'h1008, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 2'b01, 1'b0, acc);
        wait_rsp(acc, 6);

        // Write with ready low 5 cycles on beat 2: fields held, rsp 5 cycles later.
        setup_bus(4, 2, 5);
        push_cmds(64'h2000_0000_0000_0010, 1'b1, 1'b0, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);
        exp_rsp_q.push_back({2'b11, WR, 128'h0});
        issue_req(WR, 64'h2000_0000_0000_0014, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF,
                  2'b11, 1'b0, acc);
        wait_rsp(acc, 11);
        check("err_after_stall", err, 0);

        // Unsupported opcode: ack, response next cycle, no bus traffic, err set.
        setup_bus(4, -1, 0);
        exp_rsp_q.push_back({2'b00, 5'd3, 128'h0});
        issue_req(5'd3, 64'h500, '1, 2'b00, 1'b0, acc);
        wait_rsp(acc, 2);
        check("err_bad_opcode", err, 1);

        // Reset in the middle of a read: outputs clear at once, no response.
        setup_bus(4, -1, 0);
        rdata_vals = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
        push_cmds(64'h3000, 1'b0, 1'b0, '0);
        issue_req(RD, 64'h3000, '0, 2'b01, 1'b0, acc);
        for (int k = 0; k < 50 && hs_cnt < 2; k++) @(negedge clk);
        check("beat1_reached", hs_cnt >= 2, 1);
        reset_n       = 1'b0;
        mem_req_valid = 1'b0;
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Follow-up read completes normally after the abort.
        setup_bus(4, -1, 0);
        rdata_vals = '{32'hC0DE_0000, 32'hC0DE_1111, 32'hC0DE_2222, 32'hC0DE_3333};
        push_cmds(64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, '0);
        exp_rsp_q.push_back({2'b10, RD, 128'hC0DE_3333_C0DE_2222_C0DE_1111_C0DE_0000});
        issue_req(RD, 64'hFFFF_FFFF_FFFF_FFF8, '0, 2'b10, 1'b0, acc);
        wait_rsp(acc, 7);
        check("err_after_reset", err, 0);

        // Stray read beat while idle is ignored but flagged.
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        check("err_stray_rdata", err, 1);
        check("busy_after_stray", busy, 0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // Watchdog: only 2 beats return; rsp 16 cycles after the last cmd beat.
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("err_cleared", err, 0);
        setup_bus(2, -1, 0);
        rdata_vals = '{32'h7777_0000, 32'h7777_0001, 32'h0, 32'h0};
        push_cmds(64'h4000, 1'b0, 1'b0, '0);
        exp_rsp_q.push_back({2'b11, RD, 128'h0000_0000_0000_0000_7777_0001_7777_0000});
        issue_req(RD, 64'h4000, '0, 2'b11, 1'b0, acc);
        wait_rsp(acc, 21);
        check("err_timeout", err, 1);
`endif

        repeat (3) @(negedge clk);
        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        check("rsp_queue_drained", exp_rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
